// File: rtl/fifo_pkg.sv
// Shared FIFO constants and width helper
// for the sync FIFO and its readers.
package fifo_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Small circular register buffer with
// wr/rd pointers and an occupancy count.
module skid_buf
  import fifo_pkg::*;
#(
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = 3,
  localparam int PW   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
  localparam int OW   = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [OW-1:0] occupancy
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [OW-1:0] r_occ;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;
  logic          w_full;

  // Depth need not be a power of two.
  assign w_wr_nxt = (r_wr_ptr == PW'(DEPTH - 1))
                  ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_nxt = (r_rd_ptr == PW'(DEPTH - 1))
                  ? '0 : r_rd_ptr + PW'(1);
  assign w_full   = (r_occ == OW'(DEPTH));

  assign rd_data   = r_mem[r_rd_ptr];
  assign occupancy = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (wr_en) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= w_wr_nxt;
      end
      if (rd_en)
        r_rd_ptr <= w_rd_nxt;
      unique case ({wr_en, rd_en})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(wr_en && w_full));

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO drain engine: credit-gated pops,
// latency absorption, valid/ready output.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DW        = FIFO_DW,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_rdata,
  output logic             fifo_re,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] xfer_count,
  output logic             busy
);

  localparam int OW = clog2(BUF_DEPTH + 1);

  logic             r_run;
  logic             r_inflight;
  logic [CNT_W-1:0] r_xfer;
  logic [OW-1:0]    w_occ;
  logic [OW:0]      w_used;
  logic             w_pop;

  // Credits count buffered plus in-flight bytes,
  // so m_ready never reaches fifo_re.
  assign w_used  = {1'b0, w_occ}
                 + {{OW{1'b0}}, r_inflight};
  assign fifo_re = r_run & enable & ~fifo_empty
                 & (w_used < (OW+1)'(BUF_DEPTH));

  assign m_valid    = (w_occ != '0);
  assign w_pop      = m_valid & m_ready;
  assign busy       = r_inflight | m_valid;
  assign xfer_count = r_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
      r_xfer     <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= fifo_re;
      if (w_pop)
        r_xfer <= r_xfer + CNT_W'(1);
    end
  end

  skid_buf #(
    .DW    (DW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (r_inflight),
    .wr_data   (fifo_rdata),
    .rd_en     (w_pop),
    .rd_data   (m_data),
    .occupancy (w_occ)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader
// with a behavioural 16x8 sync FIFO model.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_re, m_valid, busy;
  logic [7:0]  m_data;
  logic [15:0] xfer_count;
  logic        fifo_re4, m_valid4, busy4;
  logic [7:0]  m_data4;
  logic [3:0]  xfer_count4;

  logic [7:0]  mem [16];
  int          wr_total = 0;
  int          rd_total = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  int          acc = 0;
  logic        hold = 1'b0;
  logic [7:0]  hold_data = 8'h00;

  always #5 clk = ~clk;

  fifo_stream_reader u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_re    (fifo_re),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .xfer_count (xfer_count),
    .busy       (busy)
  );

  fifo_stream_reader #(.CNT_W(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_re    (fifo_re4),
    .m_valid    (m_valid4),
    .m_data     (m_data4),
    .m_ready    (m_ready),
    .xfer_count (xfer_count4),
    .busy       (busy4)
  );

  // FIFO model: registered read data.
  assign fifo_empty = (wr_total == rd_total);

  always @(posedge clk)
    if (fifo_re) begin
      fifo_rdata <= mem[rd_total % 16];
      rd_total   <= rd_total + 1;
    end

  task automatic chk(input string nm,
                     input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_total % 16] = b;
    wr_total++;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    int p;
    rst_n = 1'b0;
    #1;
    chk("rst_fifo_re", int'(fifo_re), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_xfer", int'(xfer_count), 0);
    chk("rst_busy", int'(busy), 0);
    p = rd_total;
    repeat (3) tick();
    chk("rst_no_pop", rd_total, p);
    wr_total = rd_total;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy)
           && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_time", int'(n < budget), 1);
  endtask

  // Monitor: compares every accepted byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc  = 0;
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data),
            int'(hold_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0)
          chk("unexpected_byte", int'(m_data), -1);
        else
          chk("m_data", int'(m_data),
              int'(exp_q.pop_front()));
        chk("xfer_count", int'(xfer_count),
            acc % 65536);
        chk("xfer_count4", int'(xfer_count4),
            acc % 16);
        acc++;
      end
      hold      = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int re_n, v_n, re_f, re_l, v_f, v_l, p;
    enable  = 1'b1;
    m_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // single byte
    push(8'hA5);
    #1;
    chk("single_re_n", int'(fifo_re), 1);
    tick();
    chk("single_re_n1", int'(fifo_re), 0);
    chk("single_v_n1", int'(m_valid), 0);
    tick();
    chk("single_v_n2", int'(m_valid), 1);
    chk("single_d_n2", int'(m_data), 8'hA5);
    wait_drain(20);
    chk("single_xfer", int'(xfer_count), 1);

    // reset mid-stream
    for (int i = 0; i < 8; i++)
      push(8'h10 + 8'(i));
    repeat (3) tick();
    do_reset();
    push(8'h5A);
    wait_drain(20);
    chk("post_rst_xfer", int'(xfer_count), 1);

    // burst of 16
    do_reset();
    for (int i = 0; i < 16; i++)
      push(8'(i));
    #1;
    re_n = 0; v_n = 0;
    re_f = -1; re_l = -1; v_f = -1; v_l = -1;
    for (int c = 0; c < 24; c++) begin
      if (fifo_re) begin
        re_n++;
        if (re_f < 0) re_f = c;
        re_l = c;
      end
      if (m_valid) begin
        v_n++;
        if (v_f < 0) v_f = c;
        v_l = c;
      end
      tick();
    end
    chk("burst_pops", re_n, 16);
    chk("burst_pop_run", re_l - re_f + 1, 16);
    chk("burst_valid", v_n, 16);
    chk("burst_valid_run", v_l - v_f + 1, 16);
    chk("burst_lat", v_f - re_f, 2);
    chk("burst_busy", int'(busy), 0);
    chk("burst_xfer", int'(xfer_count), 16);
    chk("burst_xfer4", int'(xfer_count4), 0);

    // backpressure
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      push(8'(i));
    #1;
    re_n = 0;
    for (int c = 0; c < 8; c++) begin
      if (fifo_re) re_n++;
      tick();
    end
    chk("bp_pops", re_n, 3);
    chk("bp_re_off", int'(fifo_re), 0);
    for (int c = 0; c < 3; c++) begin
      chk("bp_valid", int'(m_valid), 1);
      chk("bp_data", int'(m_data), 0);
      tick();
    end
    m_ready = 1'b1;
    wait_drain(40);
    chk("bp_xfer", int'(xfer_count), 10);

    // enable drop after one pop
    do_reset();
    for (int i = 0; i < 5; i++)
      push(8'h30 + 8'(i));
    p = rd_total;
    #1;
    chk("en_pop", int'(fifo_re), 1);
    tick();
    enable = 1'b0;
    #1;
    chk("en_re_off", int'(fifo_re), 0);
    chk("en_one_pop", rd_total - p, 1);
    repeat (6) tick();
    chk("en_no_pop", rd_total - p, 1);
    chk("en_fifo_cnt", wr_total - rd_total, 4);
    chk("en_xfer", int'(xfer_count), 1);
    chk("en_busy", int'(busy), 0);
    enable = 1'b1;
    wait_drain(40);
    chk("en_xfer_all", int'(xfer_count), 5);

    // counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 16; i++)
      push(8'h40 + 8'(i));
    wait_drain(60);
    push(8'h99);
    wait_drain(20);
    chk("wrap_xfer4", int'(xfer_count4), 1);
    chk("wrap_xfer16", int'(xfer_count), 17);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
